bist_pattern_gen: RTL and testbench
===================================

Name: bist_pattern_gen

Overview:
Upstream stimulus source for combinational gates under fault simulation, such as reduction NOR/OR chains with a WIDTH-bit input bus. On start it emits a complete pattern set over a valid/ready stream. The set is one of four families: exhaustive count, maximal-length LFSR, walking-one or walking-zero. Downstream consumers are the gate input bus and a response capture stage, which use pat_index to tag each response.

Parameters:
WIDTH, 8, pattern bus width; legal range 2..16
LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1); must be maximal-length for WIDTH
LFSR_SEED, 8'h01, LFSR initial state; a value of 0 is replaced by 1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a pattern set
mode  input  2  0 exhaustive, 1 LFSR, 2 walking-one, 3 walking-zero; sampled on accepted start
pat_ready  input  1  downstream can accept pat_data this cycle
pat_valid  output  1  pat_data is valid
pat_data  output  WIDTH  current pattern
pat_index  output  WIDTH+1  zero-based ordinal of the current pattern
busy  output  1  high in RUN
done  output  1  high in DONE; sticky until the next accepted start

Behaviour:
- States: IDLE, RUN, DONE. Reset (async assert) forces IDLE with all outputs 0 and all internal registers cleared.
- IDLE or DONE with start=1: next cycle enters RUN. On that edge: mode is latched, the first pattern is loaded, pat_index=0, pat_valid=1, busy=1, done=0. Start-to-valid latency is 1 cycle.
- start is ignored while in RUN. A mode change during RUN has no effect.
- Transfer occurs when pat_valid && pat_ready. Without a transfer, pat_data and pat_index hold stable.
- After a non-final transfer: next pattern on the next edge and pat_index+1. Back-to-back transfers give 1 pattern per cycle.
- Final transfer (pat_index == LEN-1): next edge enters DONE, pat_valid=0, busy=0, done=1. pat_data and pat_index hold their last values.
- LEN and pattern rule per mode:
  - Exhaustive: LEN=2^WIDTH. Patterns 0,1,...,2^WIDTH-1. Counter wraps internally, but emission stops at LEN.
  - LFSR: LEN=2^WIDTH-1. First pattern is LFSR_SEED (or 1 if seed is 0). Next state = (s>>1) ^ (s[0] ? LFSR_TAPS : 0). All-zero is never produced.
  - Walking-one: LEN=WIDTH. Patterns 1<<0 .. 1<<(WIDTH-1).
  - Walking-zero: LEN=WIDTH. Bitwise inverse of walking-one.
- pat_index has WIDTH+1 bits so the exhaustive count is representable. LEN comparison is unsigned.
- Reset asserted mid-RUN: immediate IDLE and outputs 0. No partial-set completion. The next start restarts from the first pattern.
- start in the same cycle as the final transfer in RUN is ignored; DONE is still entered.
- pat_ready may be held low indefinitely with no timeout. State is retained.

Decomposition:
- Package bist_pkg:
  - mode encodings MODE_EXH/MODE_LFSR/MODE_WALK1/MODE_WALK0
  - state enum IDLE/RUN/DONE
  - default taps/seed constants for WIDTH 8 and 16
- Sub-module bist_lfsr_next: combinational, parameterised by WIDTH and TAPS, maps state to next state.
- FSM, counter and pattern mux stay in bist_pattern_gen.

Test Plan:
1. mode=0, WIDTH=8, pat_ready=1 constantly -> 256 transfers with data 0x00..0xFF in order, pat_index 0..255; done=1 on the cycle after index 255. A NOR gate on pat_data yields 1 only at index 0.
2. mode=1, seed 0x01 -> first five patterns 0x01, 0xB8, 0x5C, 0x2E, 0x17. 255 transfers total, all distinct, none 0x00; then DONE.
3. mode=2 then mode=3 with pat_ready toggling 1,0,1,0 -> walking-one sequence 01,02,04,...,80, then FE,FD,...,7F. Data and index are stable during every ready=0 cycle.
4. pat_ready=0 for 10 cycles after start -> pat_data=0x00 and pat_index=0 held for all 10 cycles, busy=1; the first transfer occurs on the first ready=1 cycle.
5. rst pulsed at pat_index=37 in mode 0 -> pat_valid/busy/done drop immediately (asynchronously). A new start gives pat_data=0x00, pat_index=0.
6. start pulsed mid-RUN with mode=1 while running mode=0 -> the exhaustive sequence continues unaffected. start asserted with the final transfer -> DONE, no restart.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared encodings and defaults for the BIST pattern generator.
// Also holds the per-family pattern-set length helper.
package bist_pkg;

  typedef enum logic [1:0] {
    MODE_EXH   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_WALK0 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Maximal-length Galois masks: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] SEED_W16 = 16'h0001;

  // Number of patterns in one set; sized for the widest legal bus (16).
  function automatic logic [16:0] mode_len(input mode_t m, input int unsigned width);
    logic [16:0] len;
    case (m)
      MODE_EXH:  len = 17'd1 << width;
      MODE_LFSR: len = (17'd1 << width) - 17'd1;
      default:   len = 17'(width);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/bist_lfsr_next.sv
// Combinational Galois LFSR step: next = (s >> 1) ^ (s[0] ? TAPS : 0).
// One generate slice per bit so the feedback XORs are explicit.
module bist_lfsr_next #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic [WIDTH-1:0] cur_state,
  output logic [WIDTH-1:0] next_state
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == WIDTH - 1) begin : g_msb
      assign next_state[gi] = cur_state[0] & TAPS[gi];
    end else begin : g_low
      assign next_state[gi] = cur_state[gi+1] ^ (cur_state[0] & TAPS[gi]);
    end
  end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus source: streams one complete pattern set (exhaustive, LFSR,
// walking-one or walking-zero) over valid/ready, tagging each with its ordinal.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(SEED_W8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             pat_ready,
  output logic             pat_valid,
  output logic [WIDTH-1:0] pat_data,
  output logic [WIDTH:0]   pat_index,
  output logic             busy,
  output logic             done
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

  state_t           state_reg, state_next;
  mode_t            mode_reg, mode_next;
  logic [WIDTH-1:0] pat_reg, pat_next;
  logic [WIDTH:0]   index_reg, index_next;

  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] first_pat;
  logic [WIDTH-1:0] step_pat;
  logic [WIDTH:0]   last_index;
  logic             start_accept;
  logic             xfer;
  logic             final_xfer;

  bist_lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .cur_state  (pat_reg),
    .next_state (lfsr_step)
  );

  assign start_accept = start && (state_reg == IDLE || state_reg == DONE);
  assign xfer         = (state_reg == RUN) && pat_ready;
  assign last_index   = (WIDTH+1)'(mode_len(mode_reg, WIDTH) - 17'd1);
  assign final_xfer   = xfer && (index_reg == last_index);

  // First pattern depends on the mode being requested, not the latched one.
  always_comb begin
    first_pat = '0;
    case (mode_t'(mode))
      MODE_EXH:   first_pat = '0;
      MODE_LFSR:  first_pat = SEED_EFF;
      MODE_WALK1: first_pat = WIDTH'(1);
      MODE_WALK0: first_pat = ~WIDTH'(1);
      default:    first_pat = '0;
    endcase
  end

  always_comb begin
    step_pat = pat_reg;
    case (mode_reg)
      MODE_EXH:   step_pat = pat_reg + WIDTH'(1);
      MODE_LFSR:  step_pat = lfsr_step;
      MODE_WALK1: step_pat = {pat_reg[WIDTH-2:0], 1'b0};
      MODE_WALK0: step_pat = {pat_reg[WIDTH-2:0], 1'b1};
      default:    step_pat = pat_reg;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic; start is only honoured outside RUN
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      DONE:    if (start) state_next = RUN;
      RUN:     if (final_xfer) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pat_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      RUN: begin
        pat_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pattern/index only move on a non-final transfer so DONE keeps the last one.
  always_comb begin
    mode_next  = mode_reg;
    pat_next   = pat_reg;
    index_next = index_reg;
    if (start_accept) begin
      mode_next  = mode_t'(mode);
      pat_next   = first_pat;
      index_next = '0;
    end else if (xfer && !final_xfer) begin
      pat_next   = step_pat;
      index_next = index_reg + (WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= MODE_EXH;
      pat_reg   <= '0;
      index_reg <= '0;
    end else begin
      mode_reg  <= mode_next;
      pat_reg   <= pat_next;
      index_reg <= index_next;
    end
  end

  assign pat_data  = pat_reg;
  assign pat_index = index_reg;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed bench for bist_pattern_gen (WIDTH=8): all four families, ready
// stalls, asynchronous abort and start-while-running behaviour.
module tb_bist_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       pat_ready;
  logic       pat_valid;
  logic [7:0] pat_data;
  logic [8:0] pat_index;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bist_pattern_gen #(
    .WIDTH     (8),
    .LFSR_TAPS (8'hB8),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .pat_ready (pat_ready),
    .pat_valid (pat_valid),
    .pat_data  (pat_data),
    .pat_index (pat_index),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pat_valid && pat_ready)
      $display("xfer idx=%0d data=%h", pat_index, pat_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] lfsr_head [5];
  logic       seen [256];
  logic [7:0] walk_exp;
  int         nor_hits;
  int         idx;
  int         cyc;

  initial begin
    lfsr_head[0] = 8'h01; lfsr_head[1] = 8'hB8; lfsr_head[2] = 8'h5C;
    lfsr_head[3] = 8'h2E; lfsr_head[4] = 8'h17;
    rst = 1'b1; start = 1'b0; mode = 2'd0; pat_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(pat_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_data",  32'(pat_data),  32'd0);
    chk("rst_index", 32'(pat_index), 32'd0);
    rst = 1'b0;
    step();

    // 1: exhaustive, ready always high
    pat_ready = 1'b1; mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("exh_busy0", 32'(busy), 32'd1);
    nor_hits = 0;
    for (int i = 0; i < 256; i++) begin
      chk("exh_valid", 32'(pat_valid), 32'd1);
      chk("exh_data",  32'(pat_data),  32'(i));
      chk("exh_index", 32'(pat_index), 32'(i));
      if (~|pat_data) nor_hits++;
      step();
    end
    chk("exh_nor_hits", 32'(nor_hits), 32'd1);
    chk("exh_done",     32'(done),      32'd1);
    chk("exh_valid_end",32'(pat_valid), 32'd0);
    chk("exh_busy_end", 32'(busy),      32'd0);
    chk("exh_data_end", 32'(pat_data),  32'hFF);
    chk("exh_idx_end",  32'(pat_index), 32'd255);

    // 2: LFSR, all distinct and non-zero
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    mode = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("lfsr_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < 255; i++) begin
      chk("lfsr_valid", 32'(pat_valid), 32'd1);
      chk("lfsr_index", 32'(pat_index), 32'(i));
      if (i < 5) chk("lfsr_head", 32'(pat_data), 32'(lfsr_head[i]));
      chk("lfsr_nonzero", 32'(pat_data == 8'h00), 32'd0);
      chk("lfsr_unique",  32'(seen[pat_data]),    32'd0);
      seen[pat_data] = 1'b1;
      step();
    end
    chk("lfsr_done",    32'(done),      32'd1);
    chk("lfsr_idx_end", 32'(pat_index), 32'd254);

    // 3: walking-one then walking-zero with ready toggling
    for (int m = 2; m < 4; m++) begin
      mode = 2'(m); start = 1'b1;
      step();
      start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
        walk_exp = 8'h01 << idx;
        if (m == 3) walk_exp = ~walk_exp;
        chk("walk_data",  32'(pat_data),  32'(walk_exp));
        chk("walk_index", 32'(pat_index), 32'(idx));
        pat_ready = (cyc % 2 == 0);
        step();
        if (pat_ready) idx++;
        cyc++;
      end
      chk("walk_count", 32'(idx),  32'd8);
      chk("walk_done",  32'(done), 32'd1);
      chk("walk_hold",  32'(pat_data), 32'((m == 2) ? 8'h80 : 8'h7F));
    end

    // 4: ready held low after start
    pat_ready = 1'b0; mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_data",  32'(pat_data),  32'd0);
      chk("stall_index", 32'(pat_index), 32'd0);
      chk("stall_busy",  32'(busy),      32'd1);
      step();
    end
    pat_ready = 1'b1;
    step();
    chk("stall_first_xfer", 32'(pat_index), 32'd1);

    // 5: asynchronous reset at index 37
    for (int i = 0; i < 36; i++) step();
    chk("abort_at", 32'(pat_index), 32'd37);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(pat_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_done",  32'(done),      32'd0);
    chk("abort_index", 32'(pat_index), 32'd0);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;

    // 6: start mid-run and on the final transfer are both ignored
    for (int i = 0; i < 256; i++) begin
      chk("rerun_data",  32'(pat_data),  32'(i));
      chk("rerun_index", 32'(pat_index), 32'(i));
      if (i == 5) begin
        start = 1'b1; mode = 2'd1;
      end else if (i == 255) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("final_start_done",  32'(done),      32'd1);
    chk("final_start_valid", 32'(pat_valid), 32'd0);
    step();
    chk("final_start_hold", 32'(done),      32'd1);
    chk("final_start_data", 32'(pat_data),  32'hFF);
    chk("final_start_idx",  32'(pat_index), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
